// File: rtl/ysyx_22040386_csr_unit_if.sv
// rtl/ysyx_22040386_csr_unit_if.sv - request/response bundle between decode (master) and the CSR unit (slave)
//
// Request : i_CSR_valid/o_CSR_ready handshake, i_CSR_state, i_CSR_ren/wen/set,
//           i_CSR_raddr/waddr, i_CSR_wdata (rs1), i_CSR_pc
// Response: o_CSR_done strobe with o_CSR_rdata, o_CSR_redirect,
//           o_CSR_redirect_pc, o_CSR_illegal
interface ysyx_22040386_csr_unit_if;
    logic        i_CSR_valid;
    logic        o_CSR_ready;
    logic [1:0]  i_CSR_state;
    logic        i_CSR_ren;
    logic        i_CSR_wen;
    logic        i_CSR_set;
    logic [11:0] i_CSR_raddr;
    logic [11:0] i_CSR_waddr;
    logic [63:0] i_CSR_wdata;
    logic [63:0] i_CSR_pc;
    logic        o_CSR_done;
    logic [63:0] o_CSR_rdata;
    logic        o_CSR_redirect;
    logic [63:0] o_CSR_redirect_pc;
    logic        o_CSR_illegal;

    modport master (
        output i_CSR_valid, i_CSR_state, i_CSR_ren, i_CSR_wen, i_CSR_set,
               i_CSR_raddr, i_CSR_waddr, i_CSR_wdata, i_CSR_pc,
        input  o_CSR_ready, o_CSR_done, o_CSR_rdata, o_CSR_redirect,
               o_CSR_redirect_pc, o_CSR_illegal
    );

    modport slave (
        input  i_CSR_valid, i_CSR_state, i_CSR_ren, i_CSR_wen, i_CSR_set,
               i_CSR_raddr, i_CSR_waddr, i_CSR_wdata, i_CSR_pc,
        output o_CSR_ready, o_CSR_done, o_CSR_rdata, o_CSR_redirect,
               o_CSR_redirect_pc, o_CSR_illegal
    );
endinterface

// File: rtl/ysyx_22040386_csr_unit.sv
// rtl/ysyx_22040386_csr_unit.sv - machine-mode CSR file and ecall/mret trap sequencer
//
// Ports: i_CSR_clk (rising edge), i_CSR_rst_n (async, active-low),
//        csr_if (slave modport of ysyx_22040386_csr_unit_if).
// Holds mstatus (0x300), mtvec (0x305), mepc (0x341), mcause (0x342).
// FSM IDLE -> EXEC -> RESP: request latched on acceptance, CSRs updated in
// EXEC, one-cycle done in RESP.
// Optional macro CSR_MCYCLE_EN adds a free-running 64-bit mcycle at 0xB00.
module ysyx_22040386_csr_unit #(
    parameter logic [63:0] MSTATUS_RST = 64'h0000_0000_0000_1800,
    parameter logic [63:0] MTVEC_RST   = 64'h0
) (
    input  logic                           i_CSR_clk,
    input  logic                           i_CSR_rst_n,
    ysyx_22040386_csr_unit_if.slave        csr_if
);
    localparam logic [1:0]  CSR_STATE_IDLE  = 2'b00;
    localparam logic [1:0]  CSR_STATE_RW    = 2'b01;
    localparam logic [1:0]  CSR_STATE_ECALL = 2'b10;
    localparam logic [1:0]  CSR_STATE_MRET  = 2'b11;

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MCYCLE  = 12'hB00;

    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} fsm_t;
    fsm_t st_q, st_d;

    logic [1:0]  req_state;
    logic        req_ren, req_wen, req_set;
    logic [11:0] req_raddr, req_waddr;
    logic [63:0] req_wdata, req_pc;

    logic [63:0] mstatus, mtvec, mepc, mcause;
`ifdef CSR_MCYCLE_EN
    logic [63:0] mcycle;
`endif

    logic [63:0] resp_rdata, resp_pc;
    logic        resp_redirect, resp_illegal;

    logic [63:0] rd_old, wr_old, wr_val, ecall_ms, mret_ms;
    logic        rd_hit, wr_hit, illegal_c, do_write, accept;

    assign accept = (st_q == ST_IDLE) && csr_if.i_CSR_valid;

    // Old values at both addresses; the hit flags double as the legality decode.
    always_comb begin
        rd_old = '0;
        rd_hit = 1'b0;
        case (req_raddr)
            ADDR_MSTATUS: begin rd_old = mstatus; rd_hit = 1'b1; end
            ADDR_MTVEC:   begin rd_old = mtvec;   rd_hit = 1'b1; end
            ADDR_MEPC:    begin rd_old = mepc;    rd_hit = 1'b1; end
            ADDR_MCAUSE:  begin rd_old = mcause;  rd_hit = 1'b1; end
`ifdef CSR_MCYCLE_EN
            ADDR_MCYCLE:  begin rd_old = mcycle;  rd_hit = 1'b1; end
`endif
            default: ;
        endcase
    end

    always_comb begin
        wr_old = '0;
        wr_hit = 1'b0;
        case (req_waddr)
            ADDR_MSTATUS: begin wr_old = mstatus; wr_hit = 1'b1; end
            ADDR_MTVEC:   begin wr_old = mtvec;   wr_hit = 1'b1; end
            ADDR_MEPC:    begin wr_old = mepc;    wr_hit = 1'b1; end
            ADDR_MCAUSE:  begin wr_old = mcause;  wr_hit = 1'b1; end
`ifdef CSR_MCYCLE_EN
            ADDR_MCYCLE:  begin wr_old = mcycle;  wr_hit = 1'b1; end
`endif
            default: ;
        endcase
    end

    // An unimplemented address on either requested side cancels the whole access.
    always_comb begin
        illegal_c = (req_state == CSR_STATE_RW) &&
                    ((req_ren && !rd_hit) || (req_wen && !wr_hit));
        do_write  = (req_state == CSR_STATE_RW) && req_wen && !illegal_c;
        wr_val    = req_set ? (wr_old | req_wdata) : req_wdata;

        ecall_ms        = mstatus;
        ecall_ms[7]     = mstatus[3];
        ecall_ms[3]     = 1'b0;
        ecall_ms[12:11] = 2'b11;

        mret_ms         = mstatus;
        mret_ms[3]      = mstatus[7];
        mret_ms[7]      = 1'b1;
        mret_ms[12:11]  = 2'b11;
    end

    always_ff @(posedge i_CSR_clk or negedge i_CSR_rst_n) begin
        if (!i_CSR_rst_n) st_q <= ST_IDLE;
        else              st_q <= st_d;
    end

    // Next state and outputs; everything except ready is held at 0 outside RESP.
    always_comb begin
        st_d                     = st_q;
        csr_if.o_CSR_ready       = 1'b0;
        csr_if.o_CSR_done        = 1'b0;
        csr_if.o_CSR_rdata       = '0;
        csr_if.o_CSR_redirect    = 1'b0;
        csr_if.o_CSR_redirect_pc = '0;
        csr_if.o_CSR_illegal     = 1'b0;
        case (st_q)
            ST_IDLE: begin
                csr_if.o_CSR_ready = 1'b1;
                if (csr_if.i_CSR_valid) st_d = ST_EXEC;
            end
            ST_EXEC: st_d = ST_RESP;
            ST_RESP: begin
                csr_if.o_CSR_done        = 1'b1;
                csr_if.o_CSR_rdata       = resp_rdata;
                csr_if.o_CSR_redirect    = resp_redirect;
                csr_if.o_CSR_redirect_pc = resp_pc;
                csr_if.o_CSR_illegal     = resp_illegal;
                st_d                     = ST_IDLE;
            end
            default: st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_CSR_clk or negedge i_CSR_rst_n) begin
        if (!i_CSR_rst_n) begin
            req_state     <= CSR_STATE_IDLE;
            req_ren       <= 1'b0;
            req_wen       <= 1'b0;
            req_set       <= 1'b0;
            req_raddr     <= '0;
            req_waddr     <= '0;
            req_wdata     <= '0;
            req_pc        <= '0;
            mstatus       <= MSTATUS_RST;
            mtvec         <= MTVEC_RST;
            mepc          <= '0;
            mcause        <= '0;
            resp_rdata    <= '0;
            resp_pc       <= '0;
            resp_redirect <= 1'b0;
            resp_illegal  <= 1'b0;
        end else begin
            if (accept) begin
                req_state <= csr_if.i_CSR_state;
                req_ren   <= csr_if.i_CSR_ren;
                req_wen   <= csr_if.i_CSR_wen;
                req_set   <= csr_if.i_CSR_set;
                req_raddr <= csr_if.i_CSR_raddr;
                req_waddr <= csr_if.i_CSR_waddr;
                req_wdata <= csr_if.i_CSR_wdata;
                req_pc    <= csr_if.i_CSR_pc;
            end
            if (st_q == ST_EXEC) begin
                resp_rdata    <= (req_state == CSR_STATE_RW && req_ren && !illegal_c) ? rd_old : '0;
                resp_illegal  <= illegal_c;
                resp_redirect <= (req_state == CSR_STATE_ECALL) || (req_state == CSR_STATE_MRET);
                resp_pc       <= (req_state == CSR_STATE_ECALL) ? {mtvec[63:2], 2'b00} :
                                 (req_state == CSR_STATE_MRET)  ? mepc : '0;
                case (req_state)
                    CSR_STATE_RW: begin
                        if (do_write) begin
                            case (req_waddr)
                                ADDR_MSTATUS: mstatus <= {wr_val[63:13], 2'b11, wr_val[10:0]};
                                ADDR_MTVEC:   mtvec   <= wr_val;
                                ADDR_MEPC:    mepc    <= wr_val;
                                ADDR_MCAUSE:  mcause  <= wr_val;
                                default: ;
                            endcase
                        end
                    end
                    CSR_STATE_ECALL: begin
                        mepc    <= req_pc;
                        mcause  <= 64'd11;
                        mstatus <= ecall_ms;
                    end
                    CSR_STATE_MRET: mstatus <= mret_ms;
                    default: ;
                endcase
            end
        end
    end

`ifdef CSR_MCYCLE_EN
    // A write in EXEC takes priority over the free-running increment.
    always_ff @(posedge i_CSR_clk or negedge i_CSR_rst_n) begin
        if (!i_CSR_rst_n)
            mcycle <= '0;
        else if (st_q == ST_EXEC && do_write && req_waddr == ADDR_MCYCLE)
            mcycle <= wr_val;
        else
            mcycle <= mcycle + 64'd1;
    end
`endif
endmodule

// File: tb/tb_ysyx_22040386_csr_unit.sv
// tb/tb_ysyx_22040386_csr_unit.sv - self-checking bench for ysyx_22040386_csr_unit
module tb_ysyx_22040386_csr_unit;
    localparam logic [1:0] S_IDLE = 2'b00, S_RW = 2'b01, S_ECALL = 2'b10, S_MRET = 2'b11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    ysyx_22040386_csr_unit_if csr_if ();

    ysyx_22040386_csr_unit dut (
        .i_CSR_clk   (clk),
        .i_CSR_rst_n (rst_n),
        .csr_if      (csr_if)
    );

    // Reference model: implemented CSRs are exactly the keys present.
    logic [63:0] csr_m [logic [11:0]];

    task automatic model_reset();
        csr_m.delete();
        csr_m[12'h300] = 64'h1800;
        csr_m[12'h305] = 64'h0;
        csr_m[12'h341] = 64'h0;
        csr_m[12'h342] = 64'h0;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive_idle();
        csr_if.i_CSR_valid = 1'b0;
        csr_if.i_CSR_state = S_IDLE;
        csr_if.i_CSR_ren   = 1'b0;
        csr_if.i_CSR_wen   = 1'b0;
        csr_if.i_CSR_set   = 1'b0;
        csr_if.i_CSR_raddr = '0;
        csr_if.i_CSR_waddr = '0;
        csr_if.i_CSR_wdata = '0;
        csr_if.i_CSR_pc    = '0;
    endtask

    // One full request; valid is held through EXEC/RESP to prove no re-acceptance.
    task automatic req(input logic [1:0] st, input logic ren, input logic wen, input logic set,
                       input logic [11:0] ra, input logic [11:0] wa,
                       input logic [63:0] wd, input logic [63:0] pcv,
                       output logic [63:0] got_rdata, output logic [63:0] got_rpc);
        logic [63:0] e_rdata, e_rpc, v, ms;
        logic        e_ill, e_redir;
        int          lat;
        e_ill = 1'b0;
        if (st == S_RW) begin
            if (ren && !csr_m.exists(ra)) e_ill = 1'b1;
            if (wen && !csr_m.exists(wa)) e_ill = 1'b1;
        end
        e_rdata = (st == S_RW && ren && !e_ill) ? csr_m[ra] : 64'h0;
        e_redir = (st == S_ECALL) || (st == S_MRET);
        e_rpc   = 64'h0;
        ms      = csr_m[12'h300];
        if (st == S_RW && wen && !e_ill) begin
            v = set ? (csr_m[wa] | wd) : wd;
            if (wa == 12'h300) v = v | 64'h1800;
            csr_m[wa] = v;
        end else if (st == S_ECALL) begin
            e_rpc = csr_m[12'h305] & ~64'h3;
            csr_m[12'h341] = pcv;
            csr_m[12'h342] = 64'd11;
            csr_m[12'h300] = (ms & ~64'h88) | (((ms >> 3) & 64'h1) << 7) | 64'h1800;
        end else if (st == S_MRET) begin
            e_rpc = csr_m[12'h341];
            csr_m[12'h300] = (ms & ~64'h88) | (((ms >> 7) & 64'h1) << 3) | 64'h80 | 64'h1800;
        end

        csr_if.i_CSR_state = st;
        csr_if.i_CSR_ren   = ren;
        csr_if.i_CSR_wen   = wen;
        csr_if.i_CSR_set   = set;
        csr_if.i_CSR_raddr = ra;
        csr_if.i_CSR_waddr = wa;
        csr_if.i_CSR_wdata = wd;
        csr_if.i_CSR_pc    = pcv;
        csr_if.i_CSR_valid = 1'b1;
        #1;
        check("ready_idle", {63'h0, csr_if.o_CSR_ready}, 64'h1);
        lat = 0;
        while (lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
            if (csr_if.o_CSR_done) break;
            check("ready_busy", {63'h0, csr_if.o_CSR_ready}, 64'h0);
        end
        check("latency", 64'(lat), 64'd2);
        check("ready_resp", {63'h0, csr_if.o_CSR_ready}, 64'h0);
        check("rdata", csr_if.o_CSR_rdata, e_rdata);
        check("illegal", {63'h0, csr_if.o_CSR_illegal}, {63'h0, e_ill});
        check("redirect", {63'h0, csr_if.o_CSR_redirect}, {63'h0, e_redir});
        check("redirect_pc", csr_if.o_CSR_redirect_pc, e_rpc);
        got_rdata = csr_if.o_CSR_rdata;
        got_rpc   = csr_if.o_CSR_redirect_pc;
        csr_if.i_CSR_valid = 1'b0;
        @(posedge clk);
        #1;
        check("done_one_cycle", {63'h0, csr_if.o_CSR_done}, 64'h0);
        check("ready_back", {63'h0, csr_if.o_CSR_ready}, 64'h1);
    endtask

    function automatic logic [11:0] pick_addr();
        logic [11:0] pool [6];
        pool[0] = 12'h300; pool[1] = 12'h305; pool[2] = 12'h341;
        pool[3] = 12'h342; pool[4] = 12'h7C0;
`ifdef CSR_MCYCLE_EN
        pool[5] = 12'h344;
`else
        pool[5] = 12'hB00;
`endif
        return pool[$urandom_range(0, 5)];
    endfunction

    initial begin
        logic [63:0] rd, rp, wd;
        int          seen;
        drive_idle();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {63'h0, csr_if.o_CSR_ready}, 64'h1);
        check("rst_done", {63'h0, csr_if.o_CSR_done}, 64'h0);
        check("rst_rdata", csr_if.o_CSR_rdata, 64'h0);
        check("rst_redirect", {63'h0, csr_if.o_CSR_redirect}, 64'h0);
        check("rst_illegal", {63'h0, csr_if.o_CSR_illegal}, 64'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        req(S_RW, 1, 0, 0, 12'h300, 12'h000, 64'h0, 64'h0, rd, rp);
        check("mstatus_rst", rd, 64'h1800);

        req(S_RW, 0, 1, 0, 12'h000, 12'h305, 64'h8000_0103, 64'h0, rd, rp);
        req(S_ECALL, 0, 0, 0, 12'h000, 12'h000, 64'h0, 64'h8000_0040, rd, rp);
        check("ecall_target", rp, 64'h8000_0100);
        req(S_RW, 1, 0, 0, 12'h341, 12'h000, 64'h0, 64'h0, rd, rp);
        check("mepc_after_ecall", rd, 64'h8000_0040);
        req(S_RW, 1, 0, 0, 12'h342, 12'h000, 64'h0, 64'h0, rd, rp);
        check("mcause_after_ecall", rd, 64'd11);

        req(S_RW, 0, 1, 0, 12'h000, 12'h300, 64'h1808, 64'h0, rd, rp);
        req(S_ECALL, 0, 0, 0, 12'h000, 12'h000, 64'h0, 64'h8000_0040, rd, rp);
        req(S_RW, 1, 0, 0, 12'h300, 12'h000, 64'h0, 64'h0, rd, rp);
        check("mstatus_ecall", rd, 64'h1880);
        req(S_MRET, 0, 0, 0, 12'h000, 12'h000, 64'h0, 64'h0, rd, rp);
        check("mret_target", rp, 64'h8000_0040);
        req(S_RW, 1, 0, 0, 12'h300, 12'h000, 64'h0, 64'h0, rd, rp);
        check("mstatus_mret", rd, 64'h1888);

        req(S_RW, 0, 1, 0, 12'h000, 12'h341, 64'hF0, 64'h0, rd, rp);
        req(S_RW, 1, 1, 1, 12'h341, 12'h341, 64'h0F, 64'h0, rd, rp);
        check("rs_old", rd, 64'hF0);
        req(S_RW, 1, 0, 0, 12'h341, 12'h000, 64'h0, 64'h0, rd, rp);
        check("rs_new", rd, 64'hFF);

        req(S_RW, 1, 1, 0, 12'h7C0, 12'h305, 64'hDEAD_BEEF, 64'h0, rd, rp);
        req(S_RW, 1, 0, 0, 12'h305, 12'h000, 64'h0, 64'h0, rd, rp);
        check("mtvec_unchanged", rd, 64'h8000_0103);

        for (int i = 0; i < 250; i++) begin
            wd = {$urandom(), $urandom()};
            req(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), pick_addr(), pick_addr(), wd,
                {$urandom(), $urandom()}, rd, rp);
        end

        req(S_RW, 0, 1, 0, 12'h000, 12'h341, 64'h1234, 64'h0, rd, rp);
        csr_if.i_CSR_state = S_ECALL;
        csr_if.i_CSR_pc    = 64'h8000_0400;
        csr_if.i_CSR_valid = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        csr_if.i_CSR_valid = 1'b0;
        #1;
        check("midrst_ready", {63'h0, csr_if.o_CSR_ready}, 64'h1);
        seen = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (csr_if.o_CSR_done) seen++;
            @(posedge clk);
            #1;
        end
        check("midrst_no_done", 64'(seen), 64'd0);
        model_reset();
        req(S_RW, 1, 0, 0, 12'h341, 12'h000, 64'h0, 64'h0, rd, rp);
        check("midrst_mepc", rd, 64'h0);
        req(S_RW, 1, 0, 0, 12'h300, 12'h000, 64'h0, 64'h0, rd, rp);
        check("midrst_mstatus", rd, 64'h1800);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
